// File: rtl/pipelined_prefix_adder.sv
// Three-stage Kogge-Stone adder/subtractor with valid/ready handshake on both sides.
// Carry-in is folded into bit 0's generate so the tree spans exactly log2(WIDTH) levels.
module pipelined_prefix_adder #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG = $clog2(WIDTH);
    localparam int L1  = (LOG + 1) / 2;

    logic             v1, v2, v3;
    logic             adv1, adv2, adv3;
    logic [WIDTH-1:0] p1, g1;
    logic             c01;
    logic [TAG_W-1:0] tag1;
    logic [WIDTH-1:0] p2, gg2, pp2;
    logic             c02;
    logic [TAG_W-1:0] tag2;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [WIDTH-1:0] tree1_g, tree1_p;
    logic [WIDTH-1:0] tree2_g;
    logic [WIDTH-1:0] sum_n;

    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v3;

    assign b_eff = b ^ {WIDTH{sub}};
    assign c0    = cin ^ sub;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            p1   <= '0;
            g1   <= '0;
            c01  <= 1'b0;
            tag1 <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                p1   <= a ^ b_eff;
                g1   <= a & b_eff;
                c01  <= c0;
                tag1 <= tag;
            end
        end
    end

    // Low levels of the tree; c0 enters as a grey cell merged into bit 0.
    always_comb begin : tree_lo
        logic [WIDTH-1:0] gt, pt, ones;
        ones  = '1;
        gt    = g1;
        pt    = p1;
        gt[0] = g1[0] | (p1[0] & c01);
        for (int unsigned lvl = 0; lvl < L1; lvl++) begin
            gt = gt | (pt & (gt << (1 << lvl)));
            pt = pt & ((pt << (1 << lvl)) | ~(ones << (1 << lvl)));
        end
        tree1_g = gt;
        tree1_p = pt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2   <= 1'b0;
            p2   <= '0;
            gg2  <= '0;
            pp2  <= '0;
            c02  <= 1'b0;
            tag2 <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                p2   <= p1;
                gg2  <= tree1_g;
                pp2  <= tree1_p;
                c02  <= c01;
                tag2 <= tag1;
            end
        end
    end

    always_comb begin : tree_hi
        logic [WIDTH-1:0] gt, pt;
        gt = gg2;
        pt = pp2;
        for (int unsigned lvl = L1; lvl < LOG; lvl++) begin
            gt = gt | (pt & (gt << (1 << lvl)));
            pt = pt & ((pt << (1 << lvl)) | ~({WIDTH{1'b1}} << (1 << lvl)));
        end
        tree2_g = gt;
    end

    // gt[i] is the carry into bit i+1; bit 0's carry is c0 itself.
    assign sum_n = p2 ^ {tree2_g[WIDTH-2:0], c02};

    always_ff @(posedge clk) begin
        if (rst) begin
            v3      <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b1;
            out_tag <= '0;
        end else if (adv3) begin
            v3 <= v2;
            if (v2) begin
                sum     <= sum_n;
                cout    <= tree2_g[WIDTH-1];
                ovf     <= tree2_g[WIDTH-1] ^ tree2_g[WIDTH-2];
                zero    <= (sum_n == '0);
                out_tag <= tag2;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench: 32-bit and 8-bit instances, vector tables plus scoreboard queues.
module tb_pipelined_prefix_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;
    logic [3:0]  tag, out_tag;

    logic        rst8, in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8, zero8;
    logic [7:0]  a8, b8, sum8;
    logic [1:0]  tag8, out_tag8;

    pipelined_prefix_adder #(.WIDTH(32), .TAG_W(4)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .zero(zero), .out_tag(out_tag)
    );

    pipelined_prefix_adder #(.WIDTH(8), .TAG_W(2)) u8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .tag(tag8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8),
        .ovf(ovf8), .zero(zero8), .out_tag(out_tag8)
    );

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        logic [3:0]  tag;
        logic [31:0] sum;
        logic        cout, ovf, zero;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout, ovf, zero;
        logic [3:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];
    exp_t drv_exp, drv8;

    function automatic logic [63:0] pk(logic [31:0] s, logic c, logic o, logic z, logic [3:0] t);
        return {25'd0, t, c, o, z, s};
    endfunction

    function automatic vec_t model(logic [31:0] va, logic [31:0] vb, logic vc, logic vs, logic [3:0] vt);
        vec_t v;
        logic [31:0] be;
        logic [32:0] r;
        be = vs ? ~vb : vb;
        r  = {1'b0, va} + {1'b0, be} + {32'd0, vc ^ vs};
        v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.tag = vt;
        v.sum  = r[31:0];
        v.cout = r[32];
        v.ovf  = (va[31] == be[31]) && (r[31] != va[31]);
        v.zero = (r[31:0] == 32'd0);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    function automatic exp_t to_exp(vec_t v, bit lat);
        exp_t e;
        e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf; e.zero = v.zero;
        e.tag = v.tag; e.acc = 0; e.lat = lat;
        return e;
    endfunction

    // 32-bit scoreboard monitor: push on accept, pop on emit, hold-stability while stalled.
    initial begin
        logic        hold_v;
        logic [63:0] held;
        exp_t        e;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                hold_v = 1'b0;
            end else begin
                if (hold_v && out_valid)
                    check("hold_stable", pk(sum, cout, ovf, zero, out_tag), held);
                if (in_valid && in_ready) begin
                    e = drv_exp;
                    e.acc = cyc;
                    q.push_back(e);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got tag %0d sum %h, required no output", out_tag, sum);
                    end else begin
                        e = q.pop_front();
                        check("result32", pk(sum, cout, ovf, zero, out_tag), pk(e.sum, e.cout, e.ovf, e.zero, e.tag));
                        if (e.lat) check("latency", 64'(cyc - e.acc), 64'd3);
                    end
                end
                hold_v = out_valid && !out_ready;
                held   = pk(sum, cout, ovf, zero, out_tag);
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst8) begin
                q8.delete();
            end else begin
                if (in_valid8 && in_ready8) q8.push_back(drv8);
                if (out_valid8 && out_ready8) begin
                    if (q8.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output8: got tag %0d sum %h, required no output", out_tag8, sum8);
                    end else begin
                        e = q8.pop_front();
                        check("result8", pk(32'(sum8), cout8, ovf8, zero8, 4'(out_tag8)),
                              pk(e.sum, e.cout, e.ovf, e.zero, e.tag));
                    end
                end
            end
        end
    end

    task automatic send(input vec_t v, input bit lat);
        bit ok;
        drv_exp = to_exp(v, lat);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; tag = v.tag;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready stuck at 0, required 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send8(input vec_t v);
        bit ok;
        drv8 = to_exp(v, 1'b0);
        a8 = v.a[7:0]; b8 = v.b[7:0]; cin8 = v.cin; sub8 = v.sub; tag8 = v.tag[1:0];
        in_valid8 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout8: in_ready stuck at 0, required 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0 && q8.size() == 0) break;
        end
        chk1(name, (q.size() == 0 && q8.size() == 0), 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        vec_t tv[8];
        vec_t t8[3];
        bit   rnd_done;
        bit   seen;

        tv[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd3, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tv[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd5, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tv[2] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 4'd6, 32'h2345678A, 1'b0, 1'b0, 1'b0};
        tv[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 4'd7, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tv[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'd8, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tv[5] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 4'd9, 32'h00000006, 1'b1, 1'b0, 1'b0};
        tv[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 4'd10, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tv[7] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'd11, 32'h00000000, 1'b1, 1'b1, 1'b1};

        t8[0] = '{32'hF0, 32'h0F, 1'b1, 1'b0, 4'd1, 32'h00, 1'b1, 1'b0, 1'b1};
        t8[1] = '{32'h80, 32'h01, 1'b0, 1'b1, 4'd2, 32'h7F, 1'b1, 1'b1, 1'b0};
        t8[2] = '{32'h7F, 32'h01, 1'b0, 1'b0, 4'd3, 32'h80, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b1; a = 32'd5; b = '0; cin = 1'b0; sub = 1'b0; tag = 4'd1;
        out_ready = 1'b1;
        rst8 = 1'b1; in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; tag8 = '0;
        out_ready8 = 1'b1;
        drv_exp = to_exp(model(32'd5, 32'd0, 1'b0, 1'b0, 4'd1), 1'b0);
        drv8 = drv_exp;

        // Reset held two cycles while an operation is offered; it must never appear.
        @(posedge clk);
        @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        check("rst_outputs", pk(sum, cout, ovf, zero, out_tag), pk(32'd0, 1'b0, 1'b0, 1'b1, 4'd0));
        @(posedge clk);
        #1;
        rst = 1'b0; rst8 = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);
        chk1("post_rst_out_valid", out_valid, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk1("rst_op_discarded", seen, 1'b0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) send(tv[i], i == 0);
        drain("drain_table");

        // Backpressure: five tagged ops, consumer stalls then releases.
        fork
            begin
                for (int k = 0; k < 5; k++)
                    send(model(32'h0100_0000 * k + 32'h1234, 32'h0000_0F00 + k, 1'b0, 1'b0, 4'(k)), 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk1("bp_full_in_ready", in_ready, 1'b0);
                chk1("bp_out_valid", out_valid, 1'b1);
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk1("bp_stream", out_valid, 1'b1);
                end
            end
        join
        drain("drain_bp");

        // Randomised traffic with random consumer stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    logic [31:0] ra, rb;
                    logic        rs;
                    ra = $urandom;
                    rb = $urandom;
                    rs = 1'($urandom_range(0, 1));
                    if (k % 5 == 0) begin
                        rb = ra;
                        rs = 1'b1;
                    end
                    send(model(ra, rb, (k % 5 == 0) ? 1'b0 : 1'($urandom_range(0, 1)), rs, 4'(k)), 1'b0);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("drain_random");

        for (int i = 0; i < 3; i++) send8(t8[i]);
        drain("drain_w8");

        // Mid-stream reset with two ops in flight on the 8-bit instance.
        send8(t8[0]);
        send8(t8[1]);
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        @(negedge clk);
        chk1("w8_post_rst_in_ready", in_ready8, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | out_valid8;
        end
        chk1("w8_rst_discard", seen, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
